// File: rtl/glift_serial_addsub.sv
// Bit-serial WIDTH-bit adder/subtractor with gate-level information flow
// tracking (GLIFT). One full-adder slice is reused across WIDTH clock
// cycles, LSB first. The carry and its taint live in registers between
// cycles. Results stay stable from one done pulse to the next.
module glift_serial_addsub #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             sub_t,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [WIDTH-1:0] a_t,
    input  logic [WIDTH-1:0] b_t,
    input  logic             cin_t,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic [WIDTH-1:0] sum_t,
    output logic             cout,
    output logic             cout_t
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;

    // Effective operands latched at accept. B is already inverted for subtract.
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_a_t;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] op_b_t;

    logic             carry;
    logic             carry_t;
    logic [CNT_W-1:0] cnt;

    // Partial results. Each new bit enters at the MSB, so bit 0 reaches the LSB last.
    logic [WIDTH-1:0] sum_sh;
    logic [WIDTH-1:0] sum_t_sh;

    // Signals of the single GLIFT full-adder slice.
    logic x, x_t, y, y_t;
    logic s1, s1_t, c1, c1_t;
    logic s2, s2_t, c2, c2_t;
    logic c_next, c_next_t;

    // Build the full adder from two half adders. The taint of each AND and
    // the final OR is precise: it flags a bit only when that bit can change the result.
    always_comb begin
        // NOTE: every signal gets a default first, so no path through the block can infer a latch.
        x        = op_a[cnt];
        x_t      = op_a_t[cnt];
        y        = op_b[cnt];
        y_t      = op_b_t[cnt];

        s1       = x ^ y;
        s1_t     = x_t | y_t;
        c1       = x & y;
        c1_t     = (x & y_t) | (y & x_t) | (x_t & y_t);

        s2       = carry ^ s1;
        s2_t     = carry_t | s1_t;
        c2       = carry & s1;
        c2_t     = (carry & s1_t) | (s1 & carry_t) | (carry_t & s1_t);

        c_next   = c1 | c2;
        c_next_t = (~c1 & c2_t) | (~c2 & c1_t) | (c1_t & c2_t);
    end

    // Control FSM, operand capture, serial datapath and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: all state is cleared here, including the operand and shift registers. They are flops, not RAM, so reset costs little and the block powers up fully defined.
            state    <= IDLE;
            op_a     <= '0;
            op_a_t   <= '0;
            op_b     <= '0;
            op_b_t   <= '0;
            carry    <= 1'b0;
            carry_t  <= 1'b0;
            cnt      <= '0;
            sum_sh   <= '0;
            sum_t_sh <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            sum_t    <= '0;
            cout     <= 1'b0;
            cout_t   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout. Every flop samples pre-edge values, so the order of statements does not matter.
            unique case (state)
                IDLE, DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        op_a    <= a;
                        op_a_t  <= a_t;
                        op_b    <= b ^ {WIDTH{sub}};
                        op_b_t  <= b_t | {WIDTH{sub_t}};
                        carry   <= sub ? 1'b1 : cin;
                        carry_t <= sub ? sub_t : cin_t;
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= RUN;
                    end else begin
                        state   <= IDLE;
                    end
                end

                RUN: begin
                    carry    <= c_next;
                    carry_t  <= c_next_t;
                    sum_sh   <= {s2, sum_sh[WIDTH-1:1]};
                    sum_t_sh <= {s2_t, sum_t_sh[WIDTH-1:1]};
                    if (cnt == LAST_BIT) begin
                        // The last bit goes directly into the visible results.
                        sum    <= {s2, sum_sh[WIDTH-1:1]};
                        sum_t  <= {s2_t, sum_t_sh[WIDTH-1:1]};
                        cout   <= c_next;
                        cout_t <= c_next_t;
                        cnt    <= '0;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        cnt    <= cnt + 1'b1;
                    end
                end

                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_glift_serial_addsub.sv
// Testbench for glift_serial_addsub with WIDTH=8. Directed and random
// operations are compared against a word-level reference model. The
// model applies the GLIFT taint rules bit by bit.
module tb_glift_serial_addsub;

    localparam int W = 8;

    typedef struct {
        logic         sub, sub_t, cin, cin_t;
        logic [W-1:0] a, b, a_t, b_t;
    } op_t;

    typedef struct packed {
        logic [W-1:0] sum;
        logic [W-1:0] sum_t;
        logic         cout;
        logic         cout_t;
    } res_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic         sub = 1'b0, sub_t = 1'b0, cin = 1'b0, cin_t = 1'b0;
    logic [W-1:0] a = '0, b = '0, a_t = '0, b_t = '0;
    logic         busy, done, cout, cout_t;
    logic [W-1:0] sum, sum_t;

    int   n_checks = 0;
    int   n_errors = 0;
    res_t held;

    glift_serial_addsub #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .sub_t(sub_t),
        .a(a), .b(b), .cin(cin), .a_t(a_t), .b_t(b_t), .cin_t(cin_t),
        .busy(busy), .done(done), .sum(sum), .sum_t(sum_t),
        .cout(cout), .cout_t(cout_t)
    );

    always #5 clk = ~clk;

    function automatic logic and_t(logic x, logic xt, logic y, logic yt);
        return (x & yt) | (y & xt) | (xt & yt);
    endfunction

    function automatic logic or_t(logic x, logic xt, logic y, logic yt);
        return (~x & yt) | (~y & xt) | (xt & yt);
    endfunction

    // Compute the value with plain arithmetic. Compute the taint from the GLIFT rules for each half adder.
    function automatic res_t model(op_t o);
        res_t         r;
        logic [W-1:0] bb, bbt;
        logic [W:0]   total;
        logic         c, ct, s1, s1t, c1, c1t, c2, c2t;
        bb    = o.sub ? ~o.b : o.b;
        bbt   = o.b_t | {W{o.sub_t}};
        c     = o.sub ? 1'b1 : o.cin;
        ct    = o.sub ? o.sub_t : o.cin_t;
        total = {1'b0, o.a} + {1'b0, bb} + {{W{1'b0}}, c};
        r.sum  = total[W-1:0];
        r.cout = total[W];
        for (int i = 0; i < W; i++) begin
            s1  = o.a[i] ^ bb[i];
            s1t = o.a_t[i] | bbt[i];
            c1  = o.a[i] & bb[i];
            c1t = and_t(o.a[i], o.a_t[i], bb[i], bbt[i]);
            r.sum_t[i] = ct | s1t;
            c2  = c & s1;
            c2t = and_t(c, ct, s1, s1t);
            ct  = or_t(c1, c1t, c2, c2t);
            c   = c1 | c2;
        end
        r.cout_t = ct;
        return r;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.a = W'($urandom); o.b = W'($urandom);
        o.a_t = W'($urandom) & W'($urandom); o.b_t = W'($urandom) & W'($urandom);
        o.sub = 1'($urandom); o.sub_t = 1'($urandom_range(0, 3) == 0);
        o.cin = 1'($urandom); o.cin_t = 1'($urandom);
        return o;
    endfunction

    function automatic op_t mk(logic s, logic st, logic [W-1:0] av, logic [W-1:0] bv,
                               logic c, logic ctv, logic [W-1:0] at, logic [W-1:0] bt);
        op_t o;
        o.sub = s; o.sub_t = st; o.a = av; o.b = bv;
        o.cin = c; o.cin_t = ctv; o.a_t = at; o.b_t = bt;
        return o;
    endfunction

    task automatic drive(op_t o);
        a = o.a; b = o.b; a_t = o.a_t; b_t = o.b_t;
        sub = o.sub; sub_t = o.sub_t; cin = o.cin; cin_t = o.cin_t;
        start = 1'b1;
    endtask

    function automatic res_t observed();
        res_t r;
        r.sum = sum; r.sum_t = sum_t; r.cout = cout; r.cout_t = cout_t;
        return r;
    endfunction

    // Call at a negedge with start already driven. Returns at the negedge
    // inside the done cycle. poke_at >= 0 pulses a stray start during RUN.
    task automatic wait_result(op_t o, string name, int poke_at);
        res_t exp_r;
        bit   seen;
        exp_r = model(o);
        seen  = 1'b0;
        @(posedge clk);
        for (int n = 0; n <= W + 4 && !seen; n++) begin
            @(negedge clk);
            if (n == 0) begin
                start = 1'b0;
                drive(rand_op());
                start = 1'b0;
            end
            if (n == poke_at) drive(rand_op());
            if (n == poke_at + 1) start = 1'b0;
            if (done) begin
                seen = 1'b1;
                n_checks++;
                if (n != W) begin
                    n_errors++;
                    $display("FAIL %s latency: done after %0d edges, expected %0d", name, n, W);
                end
                n_checks++;
                if (observed() !== exp_r || busy !== 1'b0) begin
                    n_errors++;
                    $display("FAIL %s result: got sum=%h sum_t=%h cout=%b cout_t=%b busy=%b, expected %h %h %b %b busy=0",
                             name, sum, sum_t, cout, cout_t, busy,
                             exp_r.sum, exp_r.sum_t, exp_r.cout, exp_r.cout_t);
                end
                held = exp_r;
            end else begin
                n_checks++;
                if (busy !== 1'b1 || observed() !== held) begin
                    n_errors++;
                    $display("FAIL %s run cycle %0d: busy=%b sum=%h sum_t=%h, expected busy=1 held %h %h",
                             name, n, busy, sum, sum_t, held.sum, held.sum_t);
                end
            end
        end
        if (!seen) begin
            n_checks++;
            n_errors++;
            $display("FAIL %s timeout: no done within %0d cycles", name, W + 5);
        end
    endtask

    // Confirm that done lasts one cycle and that results stay put afterwards.
    task automatic check_idle(string name);
        @(negedge clk);
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || observed() !== held) begin
            n_errors++;
            $display("FAIL %s idle: done=%b busy=%b sum=%h, expected done=0 busy=0 sum=%h",
                     name, done, busy, sum, held.sum);
        end
    endtask

    task automatic run_op(op_t o, string name);
        drive(o);
        wait_result(o, name, -1);
        check_idle(name);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({busy, done, cout, cout_t, sum, sum_t} !== '0) begin
            n_errors++;
            $display("FAIL reset: busy=%b done=%b sum=%h sum_t=%h cout=%b cout_t=%b, expected all 0",
                     busy, done, sum, sum_t, cout, cout_t);
        end
        rst_n = 1'b1;
        held  = '0;
        @(negedge clk);
    endtask

    task automatic test_add();
        run_op(mk(0, 0, 8'h0F, 8'h01, 0, 0, 8'h00, 8'h00), "add_basic");
        run_op(mk(0, 0, 8'hFF, 8'h01, 0, 1, 8'h00, 8'h00), "add_cin_taint_masked");
        run_op(mk(0, 0, 8'h00, 8'h00, 0, 0, 8'h80, 8'h00), "add_msb_taint");
        run_op(mk(0, 0, 8'hFF, 8'hFF, 1, 0, 8'h00, 8'h00), "add_max");
    endtask

    task automatic test_sub();
        run_op(mk(1, 0, 8'h05, 8'h07, 1, 1, 8'h00, 8'h00), "sub_basic");
        run_op(mk(1, 1, 8'h05, 8'h07, 1, 1, 8'h00, 8'h00), "sub_tainted_op");
        run_op(mk(1, 0, 8'h80, 8'h80, 0, 0, 8'h00, 8'h00), "sub_equal");
    endtask

    task automatic test_ignore_start();
        op_t o;
        o = mk(0, 0, 8'h21, 8'h13, 1, 0, 8'h04, 8'h00);
        drive(o);
        wait_result(o, "ignore_start", 3);
        check_idle("ignore_start");
    endtask

    task automatic test_back_to_back();
        op_t o1, o2;
        o1 = mk(0, 0, 8'h40, 8'h22, 0, 0, 8'h01, 8'h00);
        o2 = mk(1, 0, 8'h10, 8'h30, 0, 0, 8'h00, 8'h08);
        drive(o1);
        wait_result(o1, "b2b_first", -1);
        drive(o2);
        wait_result(o2, "b2b_second", -1);
        check_idle("b2b_second");
    endtask

    task automatic test_reset_mid_op();
        bit bad;
        drive(mk(0, 0, 8'h55, 8'h2A, 1, 1, 8'hF0, 8'h0F));
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, cout, cout_t, sum, sum_t} !== '0) begin
            n_errors++;
            $display("FAIL reset_mid_op: busy=%b done=%b sum=%h sum_t=%h cout=%b cout_t=%b, expected all 0",
                     busy, done, sum, sum_t, cout, cout_t);
        end
        held = '0;
        @(negedge clk);
        rst_n = 1'b1;
        bad = 1'b0;
        repeat (W + 2) begin
            @(negedge clk);
            if (done !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_errors++;
            $display("FAIL reset_mid_op quiet: done or busy rose after abort, expected both 0");
        end
        run_op(mk(0, 0, 8'h03, 8'h04, 0, 0, 8'h00, 8'h00), "after_reset");
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) run_op(rand_op(), "random");
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid_op();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
